// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: management-slave
// register map, field positions, opcodes, FSM state type and the helpers that
// format the phase-step and C-counter register words.
package pll_reconfig_pkg;

  // Management-slave register addresses
  localparam logic [5:0] MODE   = 6'h00;
  localparam logic [5:0] STATUS = 6'h01;
  localparam logic [5:0] START  = 6'h02;
  localparam logic [5:0] C_CNT  = 6'h05;
  localparam logic [5:0] PHASE  = 6'h06;

  // Field bit positions
  localparam int unsigned STATUS_DONE_BIT = 0;
  localparam int unsigned PHASE_SEL_LSB   = 16;
  localparam int unsigned PHASE_UP_BIT    = 21;
  localparam int unsigned CCNT_SEL_LSB    = 18;

  // Command opcodes
  localparam logic OP_PHASE = 1'b0;
  localparam logic OP_CCNT  = 1'b1;

  typedef enum logic [2:0] {
    StInitMode,
    StIdle,
    StWrData,
    StWrStart,
    StPoll,
    StWaitLock,
    StFinish
  } state_e;

  // {10'b0, up, sel[4:0], steps[15:0]}
  function automatic logic [31:0] phase_word(input logic up, input logic [4:0] sel,
                                             input logic [15:0] steps);
    logic [31:0] w;
    w                      = '0;
    w[15:0]                = steps;
    w[PHASE_SEL_LSB +: 5]  = sel;
    w[PHASE_UP_BIT]        = up;
    return w;
  endfunction

  // {9'b0, sel[4:0], 2'b0, high[7:0], low[7:0]}
  function automatic logic [31:0] c_word(input logic [4:0] sel, input logic [15:0] hi_lo);
    logic [31:0] w;
    w                     = '0;
    w[15:0]               = hi_lo;
    w[CCNT_SEL_LSB +: 5]  = sel;
    return w;
  endfunction

endpackage

// File: rtl/avm_master_port.sv
// Single-transfer Avalon-MM master.
// A one-cycle i_req (only while no transfer is pending, or in the cycle the
// current one completes) launches a read (i_rd=1) or write. Strobe, address
// and data are registered and held while avm_waitrequest is high.
// Ports:
//   clk, reset          clock, async active-high reset
//   i_req/i_rd/i_addr/i_wdata  transfer request
//   o_ack               transfer completes this cycle
//   o_pending           a transfer is in flight
//   o_rdata             read data, valid with o_ack
//   avm_*               Avalon-MM master pins
module avm_master_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_rd,
  input  logic [5:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic        o_pending,
  output logic [31:0] o_rdata,
  output logic [5:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  logic        r_read;
  logic        r_write;
  logic [5:0]  r_addr;
  logic [31:0] r_wdata;
  logic        w_ack;

  assign w_ack = (r_read | r_write) & ~avm_waitrequest;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_req) begin
      r_read  <= i_rd;
      r_write <= ~i_rd;
      r_addr  <= i_addr;
      r_wdata <= i_rd ? 32'h0 : i_wdata;
    end else if (w_ack) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end
  end

  assign o_ack         = w_ack;
  assign o_pending     = r_read | r_write;
  assign o_rdata       = avm_readdata;
  assign avm_address   = r_addr;
  assign avm_read      = r_read;
  assign avm_write     = r_write;
  assign avm_writedata = r_wdata;

endmodule

// File: rtl/pll_phase_ctrl.sv
// PLL reconfiguration sequencer. Puts the management slave in polling mode
// after reset, then per command writes the phase or C-counter word, starts
// reconfiguration, polls status and waits for lock, with a timeout guard.
// Ports:
//   clk, reset                 clock, async active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op/cmd_cnt_sel/cmd_up/cmd_value  command fields
//   busy/done/err              status: in progress, completion pulse, sticky timeout
//   pll_locked                 async lock indicator
//   avm_*                      Avalon-MM master to the reconfig slave
module pll_phase_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned          TIMEOUT_W   = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [4:0]  cmd_cnt_sel,
  input  logic        cmd_up,
  input  logic [15:0] cmd_value,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        pll_locked,
  output logic [5:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  state_e               r_state;
  logic                 r_cmd_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [TIMEOUT_W-1:0] r_tmo_cnt;
  logic [1:0]           r_lock_sync;

  logic        w_accept;
  logic        w_tmo;
  logic        w_locked;
  logic        w_req;
  logic        w_rd;
  logic [5:0]  w_addr;
  logic [31:0] w_wdata;
  logic        w_ack;
  logic        w_pending;
  logic [31:0] w_rdata;
  logic        w_status_done;
  logic        w_unused_rdata;

  assign w_accept       = cmd_valid & r_cmd_ready;
  assign w_tmo          = (r_tmo_cnt >= TIMEOUT_MAX);
  assign w_locked       = r_lock_sync[1];
  assign w_status_done  = w_rdata[STATUS_DONE_BIT];
  assign w_unused_rdata = ^w_rdata[31:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lock_sync <= 2'b00;
    else       r_lock_sync <= {r_lock_sync[0], pll_locked};
  end

  // Transfer launches are decided combinationally so each new strobe is
  // registered on the same edge as the state change; this keeps the
  // zero-wait accept-to-done path at five cycles. The command word itself is
  // captured in the master's address/data registers at accept.
  always_comb begin
    w_req   = 1'b0;
    w_rd    = 1'b0;
    w_addr  = MODE;
    w_wdata = 32'h0;
    case (r_state)
      StInitMode: begin
        if (!w_pending) begin
          w_req   = 1'b1;
          w_addr  = MODE;
          w_wdata = 32'h1;
        end
      end
      StIdle: begin
        if (w_accept) begin
          w_req = 1'b1;
          unique case (cmd_op)
            OP_PHASE: begin
              w_addr  = PHASE;
              w_wdata = phase_word(cmd_up, cmd_cnt_sel, cmd_value);
            end
            OP_CCNT: begin
              w_addr  = C_CNT;
              w_wdata = c_word(cmd_cnt_sel, cmd_value);
            end
            default: ;
          endcase
        end
      end
      StWrData: begin
        if (w_ack) begin
          w_req   = 1'b1;
          w_addr  = START;
          w_wdata = 32'h1;
        end
      end
      StWrStart: begin
        if (w_ack) begin
          w_req  = 1'b1;
          w_rd   = 1'b1;
          w_addr = STATUS;
        end
      end
      StPoll: begin
        // Keep polling only while status is clear and the budget remains.
        if (w_ack && !w_tmo && !w_status_done) begin
          w_req  = 1'b1;
          w_rd   = 1'b1;
          w_addr = STATUS;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StInitMode;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StInitMode: begin
          if (w_ack) begin
            r_state     <= StIdle;
            r_cmd_ready <= 1'b1;
          end
        end
        StIdle: begin
          if (w_accept) begin
            r_state     <= StWrData;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
          end
        end
        StWrData: begin
          if (w_ack) r_state <= StWrStart;
        end
        StWrStart: begin
          if (w_ack) begin
            r_state   <= StPoll;
            r_tmo_cnt <= '0;
          end
        end
        StPoll: begin
          if (!w_tmo) r_tmo_cnt <= r_tmo_cnt + TIMEOUT_W'(1);
          // A read stalled at timeout is held; the abort happens on completion.
          if (w_ack) begin
            if (w_tmo) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= StFinish;
            end else if (w_status_done) begin
              r_state <= StWaitLock;
            end
          end
        end
        StWaitLock: begin
          if (!w_tmo) r_tmo_cnt <= r_tmo_cnt + TIMEOUT_W'(1);
          if (w_tmo) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= StFinish;
          end else if (w_locked) begin
            r_done  <= 1'b1;
            r_state <= StFinish;
          end
        end
        StFinish: begin
          r_state     <= StIdle;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= StInitMode;
      endcase
    end
  end

  avm_master_port u_avm (
    .clk             (clk),
    .reset           (reset),
    .i_req           (w_req),
    .i_rd            (w_rd),
    .i_addr          (w_addr),
    .i_wdata         (w_wdata),
    .o_ack           (w_ack),
    .o_pending       (w_pending),
    .o_rdata         (w_rdata),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: table of commands plus hand-written sequences for
// timeout, delayed lock and reset during polling. Expected Avalon transfers are
// queued when a command is driven and compared as the DUT performs them.
module tb_pll_phase_ctrl;

  localparam logic [19:0] TMO = 20'd100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [4:0]  cmd_cnt_sel = '0;
  logic        cmd_up = 1'b0;
  logic [15:0] cmd_value = '0;
  logic        busy, done, err;
  logic        pll_locked = 1'b1;
  logic [5:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  always #5 clk = ~clk;

  pll_phase_ctrl #(
    .TIMEOUT_W   (20),
    .TIMEOUT_MAX (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_cnt_sel     (cmd_cnt_sel),
    .cmd_up          (cmd_up),
    .cmd_value       (cmd_value),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .pll_locked      (pll_locked),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  typedef struct {
    logic        rd;
    logic [5:0]  addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    logic        op;
    logic [4:0]  sel;
    logic        up;
    logic [15:0] value;
    int          status_at;  // read number returning status done; 0 = never
    int          stall;      // waitrequest cycles per transfer
    logic [5:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  xfer_t exp_q[$];
  vec_t  vecs[6];

  int n_checks = 0;
  int n_errors = 0;

  // Slave model
  int stall_cycles  = 0;
  int stall_ctr     = 0;
  int rd_cnt        = 0;
  int status_target = 1;
  bit status_never  = 1'b0;

  assign avm_waitrequest = (avm_read | avm_write) && (stall_ctr < stall_cycles);
  assign avm_readdata    = {31'h0, (!status_never && (rd_cnt + 1 >= status_target))};

  always @(posedge clk) begin
    if (!(avm_read || avm_write)) begin
      stall_ctr <= 0;
    end else if (avm_waitrequest) begin
      stall_ctr <= stall_ctr + 1;
    end else begin
      stall_ctr <= 0;
      if (avm_read) rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic rd, input logic [5:0] a, input logic [31:0] d);
    xfer_t x;
    x.rd   = rd;
    x.addr = a;
    x.data = d;
    exp_q.push_back(x);
  endtask

  // Advance to the next falling edge and check any bus activity in that cycle.
  task automatic tick();
    logic [63:0] act;
    logic [63:0] exp;
    @(negedge clk);
    if (avm_read || avm_write) begin
      act = {24'h0, avm_read, avm_write, avm_address, (avm_write ? avm_writedata : 32'h0)};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_xfer: got 0x%0h, required no transfer", act);
      end else begin
        exp = {24'h0, exp_q[0].rd, !exp_q[0].rd, exp_q[0].addr,
               (exp_q[0].rd ? 32'h0 : exp_q[0].data)};
        chk(avm_waitrequest ? "xfer_hold" : "xfer_done", act, exp);
        if (!avm_waitrequest) void'(exp_q.pop_front());
      end
    end
  endtask

  function automatic int lat_model(input vec_t v);
    return 5 + (v.status_at - 1) + v.stall * (2 + v.status_at);
  endfunction

  task automatic run_cmd(input vec_t v, input int n_reads, input bit exp_err, input int exp_lat,
                         input bit hold_valid, input int lock_wait);
    int lat;
    int g;
    bit early;
    stall_cycles  = v.stall;
    status_never  = (v.status_at == 0);
    status_target = rd_cnt + v.status_at;
    push(1'b0, v.exp_addr, v.exp_data);
    push(1'b0, 6'h02, 32'h1);
    for (int i = 0; i < n_reads; i++) push(1'b1, 6'h01, 32'h0);
    g = 0;
    while (!cmd_ready && g < 100) begin
      tick();
      g++;
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_op      = v.op;
    cmd_cnt_sel = v.sel;
    cmd_up      = v.up;
    cmd_value   = v.value;
    cmd_valid   = 1'b1;
    tick();
    lat = 1;
    cmd_valid = hold_valid;
    chk("accept_busy_ready_err", {busy, cmd_ready, err}, 3'b100);
    if (lock_wait > 0) begin
      g = 0;
      while (exp_q.size() != 0 && g < 200) begin
        tick();
        g++;
      end
      early = 1'b0;
      repeat (lock_wait) begin
        tick();
        if (done || cmd_ready) early = 1'b1;
      end
      chk("no_done_before_lock", early, 0);
      pll_locked = 1'b1;
      lat = 0;
    end
    while (!done && lat < 2000) begin
      tick();
      lat++;
    end
    chk("done_pulse", done, 1);
    chk("latency", lat, exp_lat);
    chk("err", err, exp_err);
    chk("xfers_left", exp_q.size(), 0);
    cmd_valid = 1'b0;
    tick();
    chk("idle_after_done", {done, busy, cmd_ready}, 3'b001);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int g;

    vecs[0] = '{1'b0, 5'd2,  1'b1, 16'h0010, 3, 0, 6'h06, 32'h0022_0010};
    vecs[1] = '{1'b1, 5'd1,  1'b0, 16'h0302, 1, 4, 6'h05, 32'h0004_0302};
    vecs[2] = '{1'b0, 5'd31, 1'b0, 16'h0000, 1, 0, 6'h06, 32'h001F_0000};
    vecs[3] = '{1'b0, 5'd0,  1'b1, 16'hFFFF, 2, 1, 6'h06, 32'h0020_FFFF};
    vecs[4] = '{1'b1, 5'd31, 1'b0, 16'hFFFF, 1, 0, 6'h05, 32'h007C_FFFF};
    vecs[5] = '{1'b1, 5'd0,  1'b1, 16'h8001, 1, 2, 6'h05, 32'h0000_8001};

    // Reset values, then the single mode write and ready by cycle 2
    repeat (3) tick();
    chk("reset_outputs",
        {cmd_ready, busy, done, err, avm_read, avm_write, avm_address, avm_writedata}, 0);
    push(1'b0, 6'h00, 32'h1);
    reset = 1'b0;
    tick();
    chk("init_ready_c1", cmd_ready, 0);
    tick();
    chk("init_ready_c2", cmd_ready, 1);
    chk("init_single_write", exp_q.size(), 0);

    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i], vecs[i].status_at, 1'b0, lat_model(vecs[i]), 1'b0, 0);
    end

    // Status never sets: aborts after TMO+1 back-to-back polls
    v = vecs[2];
    v.status_at = 0;
    run_cmd(v, int'(TMO) + 1, 1'b1, int'(TMO) + 4, 1'b0, 0);
    repeat (3) tick();
    chk("err_sticky", err, 1);
    run_cmd(vecs[0], 3, 1'b0, lat_model(vecs[0]), 1'b0, 0);

    // Lock low for 50 cycles after status done, cmd_valid held throughout
    pll_locked = 1'b0;
    repeat (3) tick();
    v = '{1'b0, 5'd4, 1'b1, 16'h0001, 1, 0, 6'h06, 32'h0024_0001};
    run_cmd(v, 1, 1'b0, 3, 1'b1, 50);

    // Reset while a stalled status read is pending
    stall_cycles  = 2;
    status_never  = 1'b1;
    push(1'b0, 6'h06, 32'h0003_0005);
    push(1'b0, 6'h02, 32'h1);
    push(1'b1, 6'h01, 32'h0);
    g = 0;
    while (!cmd_ready && g < 100) begin
      tick();
      g++;
    end
    cmd_op      = 1'b0;
    cmd_cnt_sel = 5'd3;
    cmd_up      = 1'b0;
    cmd_value   = 16'h0005;
    cmd_valid   = 1'b1;
    tick();
    cmd_valid = 1'b0;
    g = 0;
    while (!(avm_read && avm_waitrequest) && g < 50) begin
      tick();
      g++;
    end
    chk("poll_read_pending", {avm_read, avm_waitrequest}, 2'b11);
    reset = 1'b1;
    #1;
    chk("reset_drops_outputs", {avm_read, avm_write, busy, cmd_ready, done}, 0);
    exp_q.delete();
    stall_cycles = 0;
    status_never = 1'b0;
    tick();
    tick();
    push(1'b0, 6'h00, 32'h1);
    reset = 1'b0;
    tick();
    tick();
    chk("reinit_ready", cmd_ready, 1);
    chk("reinit_single_write", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
